skinny_subcells_serial_ctrl: RTL

//  Serial SubCells controller for masked Skinny-64 (d=1, two shares). Sits directly

---
 rtl/skinny_subcells_serial_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/skinny_subcells_serial_ctrl.sv
// -----------------------------------------------------------------------------
// skinny_subcells_serial_ctrl
//
// Serial SubCells controller for first-order masked Skinny-64 (two shares).
// Streams one 4-bit share pair per cycle into an external pipelined masked
// S-box, supplies the S-box Fresh randomness, and reassembles the S-box
// outputs into the 64-bit masked result. Share 0 and share 1 travel in
// separate registers end to end and are never combined.
//
// Build option:
//   FRESH_LFSR_EN  defined   -> internal 32-bit LFSR drives sbox_fresh_o and
//                               the rand_i port is removed.
//                  undefined -> sbox_fresh_o follows rand_i combinationally.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   start_i                   start request, honoured only in IDLE
//   state_s0_i / state_s1_i   input state shares (latched at start)
//   busy_o                    run in progress (FEED or DRAIN)
//   done_o                    one-cycle pulse, result valid
//   state_s0_o / state_s1_o   result state shares, held until overwritten
//   sbox_x_s0_o / _s1_o       nibble shares to the S-box (registered)
//   sbox_fresh_o              Fresh randomness to the S-box
//   sbox_y_s0_i / _s1_i       nibble shares from the S-box
//   rand_i                    external randomness (only without FRESH_LFSR_EN)
// -----------------------------------------------------------------------------
module skinny_subcells_serial_ctrl #(
  parameter int          NIBBLES   = 16,
  parameter int          SBOX_LAT  = 3,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [4*NIBBLES-1:0] state_s0_i,
  input  logic [4*NIBBLES-1:0] state_s1_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*NIBBLES-1:0] state_s0_o,
  output logic [4*NIBBLES-1:0] state_s1_o,
  output logic [3:0]           sbox_x_s0_o,
  output logic [3:0]           sbox_x_s1_o,
  output logic [15:0]          sbox_fresh_o,
  input  logic [3:0]           sbox_y_s0_i,
  input  logic [3:0]           sbox_y_s1_i
`ifndef FRESH_LFSR_EN
  ,
  input  logic [15:0]          rand_i
`endif
);

  localparam int                W     = 4 * NIBBLES;
  localparam int                CNT_W = $clog2(NIBBLES) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NIBBLES - 1);

  // Elaboration-time parameter sanity.
  if (SBOX_LAT < 1) begin : g_bad_sbox_lat
    $error("SBOX_LAT must be at least 1");
  end
  if (LFSR_SEED == 32'h0) begin : g_bad_lfsr_seed
    $error("LFSR_SEED must be non-zero");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    out_cnt;
  logic [W-1:0]        sh_s0, sh_s1;
  logic [3:0]          x_s0_p0, x_s1_p0;
  logic [SBOX_LAT-1:0] vld_p;
  logic [SBOX_LAT-1:0] vld_next;
  logic [W-1:0]        res_s0, res_s1;

  logic accept;
  logic issue;
  logic capture;

  assign accept  = (state_q == IDLE) && start_i;
  assign capture = vld_p[SBOX_LAT-1];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FEED;
        end
      end
      FEED: begin
        busy_o = 1'b1;
        issue  = 1'b1;
        if (in_cnt == LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        // The last capture can never land in FEED because SBOX_LAT >= 1.
        if (capture && (out_cnt == LAST)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Valid bit follows each issued nibble through the S-box latency.
  always_comb begin
    vld_next    = vld_p << 1;
    vld_next[0] = issue;
  end

  // ---------------------------------------------------------------------------
  // Issue stage: input shift registers (pure data, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      // Nibble 0 goes straight to the S-box port; the rest wait here.
      sh_s0 <= state_s0_i >> 4;
      sh_s1 <= state_s1_i >> 4;
    end else if (issue) begin
      sh_s0 <= sh_s0 >> 4;
      sh_s1 <= sh_s1 >> 4;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue stage p0: registered S-box operands, counters, valid pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_s0_p0 <= 4'h0;
      x_s1_p0 <= 4'h0;
      in_cnt  <= '0;
      vld_p   <= '0;
    end else begin
      vld_p <= vld_next;
      if (accept) begin
        x_s0_p0 <= state_s0_i[3:0];
        x_s1_p0 <= state_s1_i[3:0];
        in_cnt  <= '0;
      end else if (issue) begin
        in_cnt <= in_cnt + 1'b1;
        if (in_cnt == LAST) begin
          // Park the S-box inputs at zero once the last nibble is out.
          x_s0_p0 <= 4'h0;
          x_s1_p0 <= 4'h0;
        end else begin
          x_s0_p0 <= sh_s0[3:0];
          x_s1_p0 <= sh_s1[3:0];
        end
      end
    end
  end

  assign sbox_x_s0_o = x_s0_p0;
  assign sbox_x_s1_o = x_s1_p0;

  // ---------------------------------------------------------------------------
  // Capture stage: S-box outputs into result nibble out_cnt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
      res_s0  <= '0;
      res_s1  <= '0;
    end else begin
      if (accept) begin
        out_cnt <= '0;
      end else if (capture) begin
        out_cnt <= out_cnt + 1'b1;
        for (int i = 0; i < NIBBLES; i++) begin
          if (out_cnt == CNT_W'(i)) begin
            res_s0[4*i +: 4] <= sbox_y_s0_i;
            res_s1[4*i +: 4] <= sbox_y_s1_i;
          end
        end
      end
    end
  end

  assign state_s0_o = res_s0;
  assign state_s1_o = res_s1;

  // ---------------------------------------------------------------------------
  // Fresh randomness
  // ---------------------------------------------------------------------------
`ifdef FRESH_LFSR_EN
  // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1, sixteen steps unrolled.
  function automatic logic [31:0] lfsr_adv16(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 16; i++) begin
      r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    end
    return r;
  endfunction

  logic [31:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if ((state_q == FEED) || (state_q == DRAIN)) begin
      lfsr_q <= lfsr_adv16(lfsr_q);
    end
  end

  assign sbox_fresh_o = lfsr_q[15:0];
`else
  assign sbox_fresh_o = rand_i;
`endif

endmodule
